// File: rtl/parking_sensor_conditioner.sv
// Front-end conditioner for the parking core: synchronises and debounces the
// two gate beams and the mode switch, turns each complete beam passage into a
// single-cycle event, and serialises coincident entry/exit events so that the
// core never sees both in the same cycle.
//
// Bit map of the conditioned inputs (sync/stable vectors):
//   [0] entry beam, [1] exit beam, [3:2] mode switch.
//
// Observation points for checkers: beam_state_q[0] / beam_state_q[1] hold the
// passage FSM states (entry / exit), exit_pend_q holds the deferred-exit flag.
module parking_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MIN_HOLD_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       entry_raw,
    input  logic       exit_raw,
    input  logic [1:0] switch_raw,
    output logic       entry_pulse,
    output logic       exit_pulse,
    output logic [1:0] switch_out,
    output logic [3:0] reject_count
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(MIN_HOLD_CYCLES + 1);

    typedef enum logic {
        IDLE    = 1'b0,
        BLOCKED = 1'b1
    } pass_state_t;

    // ------------------------------------------------------------------
    // Synchronisers
    // ------------------------------------------------------------------
    logic [3:0] raw_bits;
    logic [3:0] sync1;
    logic [3:0] sync2;

    assign raw_bits = {switch_raw, exit_raw, entry_raw};

    // Two-flop synchroniser for every asynchronous input bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_bits;
            sync2 <= sync1;
        end
    end

    // ------------------------------------------------------------------
    // Debounce
    // ------------------------------------------------------------------
    logic [3:0]      stable;
    logic [DB_W-1:0] db_cnt [4];

    // Per-bit disagreement counter; the D-th consecutive disagreeing cycle
    // flips the stable level directly rather than storing D first, so the
    // level moves DEBOUNCE_CYCLES+1 edges after the raw change is sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable[i] <= ~stable[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign switch_out = stable[3:2];

    // ------------------------------------------------------------------
    // Arming after reset
    // ------------------------------------------------------------------
    // The synchronisers come out of reset holding 0, so for two edges sync2
    // does not yet reflect the real beam. A beam is only armed once the
    // primed synchroniser shows it low while its debounced level is low;
    // a beam already broken at reset release therefore has to clear first.
    logic [1:0] prime_cnt;
    logic       primed;

    assign primed = (prime_cnt == 2'd2);

    // Count the first two edges after reset, then hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prime_cnt <= '0;
        end else if (!primed) begin
            prime_cnt <= prime_cnt + 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // Passage FSMs (index 0 = entry beam, 1 = exit beam)
    // ------------------------------------------------------------------
    pass_state_t       beam_state_q [2];
    pass_state_t       beam_state_d [2];
    logic [HOLD_W-1:0] hold_q       [2];
    logic [HOLD_W-1:0] hold_d       [2];
    logic [1:0]        armed_q;
    logic [1:0]        armed_d;
    logic [1:0]        pass_req;
    logic [1:0]        short_rej;

    // Passage state, hold counters and arm flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= '0;
            for (int b = 0; b < 2; b++) begin
                beam_state_q[b] <= IDLE;
                hold_q[b]       <= '0;
            end
        end else begin
            armed_q <= armed_d;
            for (int b = 0; b < 2; b++) begin
                beam_state_q[b] <= beam_state_d[b];
                hold_q[b]       <= hold_d[b];
            end
        end
    end

    // Next state: a rising debounced level opens a passage (the cycle it is
    // seen counts as the first held cycle), a falling level closes it and
    // either requests an event or reports a too-short block.
    always_comb begin
        armed_d   = armed_q;
        pass_req  = '0;
        short_rej = '0;
        for (int b = 0; b < 2; b++) begin
            beam_state_d[b] = beam_state_q[b];
            hold_d[b]       = hold_q[b];
            case (beam_state_q[b])
                IDLE: begin
                    if (!armed_q[b]) begin
                        if (primed && !sync2[b] && !stable[b]) begin
                            armed_d[b] = 1'b1;
                        end
                    end else if (stable[b]) begin
                        beam_state_d[b] = BLOCKED;
                        hold_d[b]       = HOLD_W'(1);
                    end
                end
                BLOCKED: begin
                    if (stable[b]) begin
                        if (hold_q[b] < HOLD_W'(MIN_HOLD_CYCLES)) begin
                            hold_d[b] = hold_q[b] + 1'b1;
                        end
                    end else begin
                        beam_state_d[b] = IDLE;
                        hold_d[b]       = '0;
                        if (hold_q[b] >= HOLD_W'(MIN_HOLD_CYCLES)) begin
                            pass_req[b] = 1'b1;
                        end else begin
                            short_rej[b] = 1'b1;
                        end
                    end
                end
                default: begin
                    beam_state_d[b] = IDLE;
                    hold_d[b]       = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Arbiter
    // ------------------------------------------------------------------
    // Entry always has priority, so only the exit channel ever needs a
    // pending flag: an exit that collides with an entry is deferred by one
    // cycle. A further exit request while one is still pending is lost.
    logic exit_pend_q;
    logic exit_pend_d;
    logic entry_fire;
    logic exit_fire;
    logic lost_event;

    // Choose which event (if any) is issued this cycle.
    always_comb begin
        exit_pend_d = exit_pend_q;
        entry_fire  = pass_req[0];
        exit_fire   = 1'b0;
        lost_event  = 1'b0;
        if (pass_req[0]) begin
            if (pass_req[1]) begin
                if (exit_pend_q) begin
                    lost_event = 1'b1;
                end else begin
                    exit_pend_d = 1'b1;
                end
            end
        end else if (exit_pend_q || pass_req[1]) begin
            exit_fire   = 1'b1;
            exit_pend_d = 1'b0;
            if (exit_pend_q && pass_req[1]) begin
                lost_event = 1'b1;
            end
        end
    end

    // Registered event pulses and the deferred-exit flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_pulse <= 1'b0;
            exit_pulse  <= 1'b0;
            exit_pend_q <= 1'b0;
        end else begin
            entry_pulse <= entry_fire;
            exit_pulse  <= exit_fire;
            exit_pend_q <= exit_pend_d;
        end
    end

    // ------------------------------------------------------------------
    // Reject counter
    // ------------------------------------------------------------------
    // Both beams and the arbiter can each reject in the same cycle, so the
    // increment is a sum rather than a single enable.
    logic [2:0] rej_inc;
    logic [4:0] rej_sum;

    assign rej_inc = {2'b00, short_rej[0]} + {2'b00, short_rej[1]} + {2'b00, lost_event};
    assign rej_sum = {1'b0, reject_count} + {2'b00, rej_inc};

    // Saturating accumulate; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reject_count <= '0;
        end else if (rej_sum > 5'd15) begin
            reject_count <= 4'd15;
        end else begin
            reject_count <= rej_sum[3:0];
        end
    end

endmodule
